branch_ctrl: RTL and testbench
==============================

Name: branch_ctrl

Overview:
- Producer side of the Fetch redirect interface: generates B, Z and B_addr, which Fetch consumes to load its PC.
- Accepts one decoded-stage instruction word plus its PC and register operands, and resolves beq, bne and j.
- Emits a one-cycle redirect pulse, then holds a flush window while the pipeline refills from the new address.
- Sits between the register-read stage and Fetch; counts taken redirects for debug.

Parameters:
- FLUSH_CYCLES, 2, cycles flush stays high after a taken redirect (legal range 1..15).
- CNT_W, 16, width of the taken-redirect counter.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- instr_valid  in  1  instr, pc, rs_data and rt_data are valid this cycle.
- ready  out  1  block can accept an instruction this cycle.
- instr  in  32  instruction word; opcode in [31:26], imm16 in [15:0], target26 in [25:0].
- pc  in  32  word address of instr, matching the Fetch addr it came from.
- rs_data  in  32  first compare operand.
- rt_data  in  32  second compare operand.
- B  out  1  branch/jump instruction resolved; pulse.
- Z  out  1  redirect taken; meaningful only while B=1.
- B_addr  out  32  redirect target word address; valid while B=1.
- flush  out  1  younger in-flight instructions must be squashed.
- taken_cnt  out  CNT_W  number of taken redirects since reset; saturates.

Behaviour:
- Reset:
  - Reset=1 at an edge forces state IDLE; B=0, Z=0, B_addr=0, flush=0, taken_cnt=0, flush counter=0.
  - ready is 1 after reset.
  - Reset wins over any simultaneous instr_valid, and aborts any state mid-operation, including an active flush window.
- Handshake:
  - Transfer occurs when instr_valid=1 and ready=1 at an edge.
  - ready=1 only in IDLE (combinational from state).
  - instr_valid while ready=0 is ignored; nothing is queued.
- Decode at transfer:
  - 6'b000100 is beq; 6'b000101 is bne; 6'b000010 is j.
  - Any other opcode is consumed with no effect; state stays IDLE and ready stays 1.
- States (IDLE, EVAL, REDIRECT, FLUSH):
  - IDLE -> EVAL on a transfer of a branch or jump; latch instr, pc, rs_data and rt_data.
  - EVAL (ready=0): compute eq = (rs_data==rt_data).
    - taken = eq for beq, !eq for bne, 1 for j.
    - Target for beq/bne: pc + 1 + sign_extend(imm16), mod 2^32. Word-addressed; wrap-around is silent.
    - Target for j: {pc[31:26], target26}.
    - Register B=1, Z=taken, B_addr=target; go to REDIRECT.
  - REDIRECT (B=1 for exactly this cycle):
    - If taken: go to FLUSH, load flush counter with FLUSH_CYCLES, set flush=1, and increment taken_cnt (saturating at all-ones).
    - If not taken: go to IDLE.
    - On leaving REDIRECT: B=0, Z=0, B_addr holds its last value.
  - FLUSH (flush=1, ready=0): decrement the counter each cycle. When it reaches 0, set flush=0 and go to IDLE.
- Latency:
  - Transfer at edge T; B/Z/B_addr visible during cycle T+2.
  - If taken, flush is high for cycles T+3 .. T+2+FLUSH_CYCLES; ready returns at cycle T+3+FLUSH_CYCLES.
  - Not taken: ready returns at cycle T+3.
- Invariants:
  - B is never high for two consecutive cycles.
  - flush and B are never high in the same cycle.
  - Z=0 whenever B=0.

Test Plan:
- Reset: hold Reset=1 for 2 cycles with instr_valid=1 and a beq → all outputs 0, ready=1, taken_cnt=0; no B pulse after release unless a new transfer occurs.
- beq taken: pc=0x10, imm16=0xFFF1 (-15), rs=rt=5 → B=1, Z=1, B_addr=0x00000002 at T+2; flush=1 for 2 cycles; ready=1 at T+5; taken_cnt=1.
- bne not taken: pc=0x20, imm16=4, rs=rt=7 → B=1, Z=0, B_addr=0x25 for one cycle; flush never asserted; ready=1 at T+3; taken_cnt unchanged.
- j with wrap: pc=0xFC000008, target26=0x0000003 → B_addr=0xFC000003, Z=1; separately, beq at pc=0xFFFFFFFF with imm16=0 and eq=1 → B_addr=0x00000000.
- Back-pressure and non-branch: hold instr_valid=1 through EVAL/REDIRECT/FLUSH → no extra transfers. Add opcode 0x23 in IDLE → no B pulse, ready stays 1. Force taken_cnt to all-ones (run 65535 taken redirects, or use a reduced CNT_W) → one further taken redirect leaves it unchanged.
- Reset mid-flush: assert Reset during FLUSH cycle 1 → next edge flush=0, state IDLE, taken_cnt=0.

Source files
------------

// File: rtl/branch_ctrl_if.sv
// Decode-to-Fetch redirect bus: instruction handshake in,
// resolved branch outcome (B/Z/B_addr) out.
interface branch_ctrl_if;
  logic        instr_valid;
  logic        ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        B;
  logic        Z;
  logic [31:0] B_addr;

  modport master (
    output instr_valid, instr, pc,
    output rs_data, rt_data,
    input  ready, B, Z, B_addr
  );

  modport slave (
    input  instr_valid, instr, pc,
    input  rs_data, rt_data,
    output ready, B, Z, B_addr
  );
endinterface

// File: rtl/branch_ctrl.sv
// Branch resolver: beq/bne/j evaluation, one-cycle redirect
// pulse to Fetch, flush window and saturating taken counter.
module branch_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  branch_ctrl_if.slave     bus,
  output logic             flush,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;
  localparam logic [5:0] OP_J   = 6'b000010;

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    REDIRECT,
    FLUSH
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      rs_q, rs_d;
  logic [31:0]      rt_q, rt_d;
  logic             b_q, b_d;
  logic             z_q, z_d;
  logic [31:0]      addr_q, addr_d;
  logic             flush_q, flush_d;
  logic [3:0]       fcnt_q, fcnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [5:0]  op_in;
  logic [5:0]  op_q;
  logic        is_br_in;
  logic        eq;
  logic        taken;
  logic [31:0] simm;
  logic [31:0] br_tgt;
  logic [31:0] j_tgt;

  assign op_in    = bus.instr[31:26];
  assign op_q     = instr_q[31:26];
  assign is_br_in = (op_in == OP_BEQ) ||
                    (op_in == OP_BNE) ||
                    (op_in == OP_J);
  assign eq       = (rs_q == rt_q);
  assign simm     = {{16{instr_q[15]}}, instr_q[15:0]};
  assign br_tgt   = pc_q + 32'd1 + simm;
  assign j_tgt    = {pc_q[31:26], instr_q[25:0]};

  always_comb begin
    taken = 1'b1;
    unique case (1'b1)
      (op_q == OP_BEQ): taken = eq;
      (op_q == OP_BNE): taken = !eq;
      default:          taken = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    b_d     = b_q;
    z_d     = z_q;
    addr_d  = addr_q;
    flush_d = flush_q;
    fcnt_d  = fcnt_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        // non-branch opcodes are accepted and dropped
        if (bus.instr_valid && is_br_in) begin
          instr_d = bus.instr;
          pc_d    = bus.pc;
          rs_d    = bus.rs_data;
          rt_d    = bus.rt_data;
          state_d = EVAL;
        end
      end
      EVAL: begin
        b_d     = 1'b1;
        z_d     = taken;
        addr_d  = (op_q == OP_J) ? j_tgt : br_tgt;
        state_d = REDIRECT;
      end
      REDIRECT: begin
        b_d = 1'b0;
        z_d = 1'b0;
        if (z_q) begin
          fcnt_d  = 4'(FLUSH_CYCLES);
          flush_d = 1'b1;
          cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
          state_d = FLUSH;
        end else begin
          state_d = IDLE;
        end
      end
      FLUSH: begin
        fcnt_d = fcnt_q - 4'd1;
        if (fcnt_q == 4'd1) begin
          flush_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      instr_q <= '0;
      pc_q    <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      b_q     <= 1'b0;
      z_q     <= 1'b0;
      addr_q  <= '0;
      flush_q <= 1'b0;
      fcnt_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      b_q     <= b_d;
      z_q     <= z_d;
      addr_q  <= addr_d;
      flush_q <= flush_d;
      fcnt_q  <= fcnt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.ready  = (state_q == IDLE);
  assign bus.B      = b_q;
  assign bus.Z      = z_q;
  assign bus.B_addr = addr_q;
  assign flush      = flush_q;
  assign taken_cnt  = cnt_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl with a 3-bit counter
// so saturation is reachable quickly.
module tb_branch_ctrl;

  logic       clk;
  logic       rst;
  logic       flush;
  logic [2:0] cnt;
  int         checks;
  int         fails;

  branch_ctrl_if bus ();

  branch_ctrl #(
    .FLUSH_CYCLES(2),
    .CNT_W(3)
  ) dut (
    .Clock(clk),
    .Reset(rst),
    .bus(bus.slave),
    .flush(flush),
    .taken_cnt(cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [5:0] BEQ = 6'b000100;
  localparam logic [5:0] BNE = 6'b000101;
  localparam logic [5:0] JMP = 6'b000010;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] ins,
                       input logic [31:0] p,
                       input logic [31:0] rs,
                       input logic [31:0] rt);
    bus.instr_valid = 1'b1;
    bus.instr       = ins;
    bus.pc          = p;
    bus.rs_data     = rs;
    bus.rt_data     = rt;
  endtask

  // transfer then run a taken redirect to completion
  task automatic run_taken(input logic [31:0] p);
    drive({JMP, 26'h0000010}, p, 32'd0, 32'd0);
    step();
    bus.instr_valid = 1'b0;
    step();
    step();
    step();
    step();
    step();
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    rst    = 1'b1;
    drive({BEQ, 10'd0, 16'h0001}, 32'h40, 32'd1, 32'd1);

    step();
    step();
    chk("rst_B", {31'd0, bus.B}, 32'd0);
    chk("rst_Z", {31'd0, bus.Z}, 32'd0);
    chk("rst_addr", bus.B_addr, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_cnt", {29'd0, cnt}, 32'd0);
    chk("rst_ready", {31'd0, bus.ready}, 32'd1);
    rst = 1'b0;
    bus.instr_valid = 1'b0;
    step();
    step();
    step();
    chk("post_rst_B", {31'd0, bus.B}, 32'd0);
    chk("post_rst_ready", {31'd0, bus.ready}, 32'd1);

    // beq taken: 0x10 + 1 - 15 = 2
    drive({BEQ, 10'd0, 16'hFFF1}, 32'h10, 32'd5, 32'd5);
    step();
    bus.instr_valid = 1'b0;
    chk("beq_t1_ready", {31'd0, bus.ready}, 32'd0);
    chk("beq_t1_B", {31'd0, bus.B}, 32'd0);
    step();
    chk("beq_B", {31'd0, bus.B}, 32'd1);
    chk("beq_Z", {31'd0, bus.Z}, 32'd1);
    chk("beq_addr", bus.B_addr, 32'h2);
    chk("beq_t2_flush", {31'd0, flush}, 32'd0);
    step();
    chk("beq_t3_B", {31'd0, bus.B}, 32'd0);
    chk("beq_t3_Z", {31'd0, bus.Z}, 32'd0);
    chk("beq_t3_flush", {31'd0, flush}, 32'd1);
    chk("beq_t3_ready", {31'd0, bus.ready}, 32'd0);
    chk("beq_cnt", {29'd0, cnt}, 32'd1);
    step();
    chk("beq_t4_flush", {31'd0, flush}, 32'd1);
    chk("beq_t4_ready", {31'd0, bus.ready}, 32'd0);
    step();
    chk("beq_t5_flush", {31'd0, flush}, 32'd0);
    chk("beq_t5_ready", {31'd0, bus.ready}, 32'd1);
    chk("beq_hold_addr", bus.B_addr, 32'h2);

    // bne not taken: 0x20 + 1 + 4 = 0x25
    drive({BNE, 10'd0, 16'h0004}, 32'h20, 32'd7, 32'd7);
    step();
    bus.instr_valid = 1'b0;
    step();
    chk("bne_B", {31'd0, bus.B}, 32'd1);
    chk("bne_Z", {31'd0, bus.Z}, 32'd0);
    chk("bne_addr", bus.B_addr, 32'h25);
    step();
    chk("bne_t3_B", {31'd0, bus.B}, 32'd0);
    chk("bne_t3_flush", {31'd0, flush}, 32'd0);
    chk("bne_t3_ready", {31'd0, bus.ready}, 32'd1);
    chk("bne_cnt", {29'd0, cnt}, 32'd1);
    chk("bne_hold_addr", bus.B_addr, 32'h25);

    // j, with instr_valid held high throughout
    drive({JMP, 26'h0000003}, 32'hFC000008, 32'd0, 32'd9);
    step();
    drive({BEQ, 10'd0, 16'h0010}, 32'h100, 32'd3, 32'd3);
    chk("j_t1_ready", {31'd0, bus.ready}, 32'd0);
    step();
    chk("j_B", {31'd0, bus.B}, 32'd1);
    chk("j_Z", {31'd0, bus.Z}, 32'd1);
    chk("j_addr", bus.B_addr, 32'hFC000003);
    step();
    chk("j_t3_B", {31'd0, bus.B}, 32'd0);
    chk("j_t3_flush", {31'd0, flush}, 32'd1);
    step();
    chk("j_t4_B", {31'd0, bus.B}, 32'd0);
    chk("j_t4_flush", {31'd0, flush}, 32'd1);
    step();
    bus.instr_valid = 1'b0;
    chk("j_t5_ready", {31'd0, bus.ready}, 32'd1);
    chk("j_t5_B", {31'd0, bus.B}, 32'd0);
    chk("j_cnt", {29'd0, cnt}, 32'd2);
    chk("j_hold_addr", bus.B_addr, 32'hFC000003);
    step();
    chk("bp_idle_ready", {31'd0, bus.ready}, 32'd1);
    chk("bp_idle_B", {31'd0, bus.B}, 32'd0);

    // beq wraps past the top of the address space
    drive({BEQ, 10'd0, 16'h0000}, 32'hFFFFFFFF, 32'd4, 32'd4);
    step();
    bus.instr_valid = 1'b0;
    step();
    chk("wrap_B", {31'd0, bus.B}, 32'd1);
    chk("wrap_Z", {31'd0, bus.Z}, 32'd1);
    chk("wrap_addr", bus.B_addr, 32'h0);
    step();
    step();
    step();
    chk("wrap_ready", {31'd0, bus.ready}, 32'd1);
    chk("wrap_cnt", {29'd0, cnt}, 32'd3);

    // non-branch opcode is consumed silently
    drive({6'h23, 26'h0000004}, 32'h50, 32'd1, 32'd1);
    step();
    bus.instr_valid = 1'b0;
    chk("nb_ready", {31'd0, bus.ready}, 32'd1);
    step();
    chk("nb_B", {31'd0, bus.B}, 32'd0);
    chk("nb_ready2", {31'd0, bus.ready}, 32'd1);
    step();
    chk("nb_B2", {31'd0, bus.B}, 32'd0);
    chk("nb_cnt", {29'd0, cnt}, 32'd3);

    // drive the counter up to saturation, then past it
    for (int i = 4; i <= 7; i++) begin
      run_taken(32'h200);
      chk("sat_ramp", {29'd0, cnt}, 32'(i));
    end
    run_taken(32'h300);
    chk("sat_hold", {29'd0, cnt}, 32'd7);
    chk("sat_ready", {31'd0, bus.ready}, 32'd1);

    // reset during the first flush cycle
    drive({BEQ, 10'd0, 16'h0002}, 32'h60, 32'd8, 32'd8);
    step();
    bus.instr_valid = 1'b0;
    step();
    step();
    chk("mid_flush_on", {31'd0, flush}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_flush", {31'd0, flush}, 32'd0);
    chk("mid_ready", {31'd0, bus.ready}, 32'd1);
    chk("mid_cnt", {29'd0, cnt}, 32'd0);
    chk("mid_B", {31'd0, bus.B}, 32'd0);
    chk("mid_addr", bus.B_addr, 32'd0);
    step();
    chk("mid_after_flush", {31'd0, flush}, 32'd0);
    chk("mid_after_B", {31'd0, bus.B}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, fails);
    $finish;
  end

endmodule
